// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: data width, reset/bubble constants,
// the fetch state encoding and a word-alignment helper.
package rv32_pkg;

  localparam int XLEN = 32;

  // Default first fetch address and bubble instruction (addi x0,x0,0).
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Fetch controller states.
  //   BOOT  : one idle cycle after reset before the first request
  //   FETCH : request presented, waiting for a grant
  //   WAIT  : request granted, waiting for its response
  //   HOLD  : a returned instruction is parked while the pipe is stalled
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;

  // Clear the byte-offset bits so an address always names a whole word.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~(32'd3);
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry instruction/PC hold register. Parks a returned instruction while
// the decode stage is stalled; emptied either by release (normal hand-off)
// or by clear (instruction squashed by a redirect).
module if_hold_buf
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            capture,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic            full
);

  logic [XLEN-1:0] instr_reg;
  logic [XLEN-1:0] pc_reg;
  logic            full_reg;

  // Capture on request; drain/clear empty the entry and restore the bubble.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      instr_reg <= NOP_INSTR;
      pc_reg    <= RESET_PC;
      full_reg  <= 1'b0;
    end else if (clear || drain) begin
      instr_reg <= NOP_INSTR;
      full_reg  <= 1'b0;
    end else if (capture) begin
      instr_reg <= instr_in;
      pc_reg    <= pc_in;
      full_reg  <= 1'b1;
    end
  end

  assign instr = instr_reg;
  assign pc    = pc_reg;
  assign full  = full_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 instruction-fetch stage. Owns the fetch PC, drives a single-outstanding
// req/gnt/rvalid instruction-memory port and presents pc_f/instr_f/pc_next_f
// to the IF/ID register. Honours stall_f and execute-stage redirects, dropping
// any response that was in flight when a redirect arrived.
//
// Build option IF_MISALIGN_TRAP_EN: adds misalign_o. A redirect to a
// non-word-aligned target then parks the fetch unit (no requests, valid_f=0,
// pc_f shows the faulting target) until the next redirect or reset. Without
// the option the target is silently aligned down to a word boundary.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_f,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_next_f,
  output logic        valid_f
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic            discard_reg, discard_next;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_block;

  logic            issue;
  logic [XLEN-1:0] issue_addr;

  logic            hold_capture;
  logic            hold_drain;
  logic            hold_clear;
  logic [XLEN-1:0] hold_instr;
  logic [XLEN-1:0] hold_pc;
  logic            hold_full;

  // Sequential PC increment; wraps silently at the top of the address space.
  assign pc_plus4 = fetch_pc_reg + 32'd4;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_reg, misalign_next;
  logic target_misaligned;

  assign target_misaligned = |pc_target_e[1:0];
  // A faulting target is latched unaligned so pc_f reports it verbatim.
  assign redirect_pc       = target_misaligned ? pc_target_e : align_word(pc_target_e);
  // A redirect decides the blocking this cycle; otherwise the sticky flag does.
  assign fetch_block       = pc_src_e ? target_misaligned : misalign_reg;
  assign misalign_next     = pc_src_e ? target_misaligned : misalign_reg;
  assign misalign_o        = misalign_reg;

  // Sticky misalignment flag, cleared by any later aligned redirect or reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= misalign_next;
    end
  end
`else
  assign redirect_pc = align_word(pc_target_e);
  assign fetch_block = 1'b0;
`endif

  // Parked instruction for stalled response cycles.
  if_hold_buf #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) u_hold_buf (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .capture  (hold_capture),
    .drain    (hold_drain),
    .clear    (hold_clear),
    .instr_in (imem_rdata_i),
    .pc_in    (fetch_pc_reg),
    .instr    (hold_instr),
    .pc       (hold_pc),
    .full     (hold_full)
  );

  // Next-state, memory request and IF/ID outputs. The response path is
  // forwarded combinationally so zero-wait memory sustains one instr/cycle.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    discard_next  = discard_reg;
    issue         = 1'b0;
    issue_addr    = fetch_pc_reg;
    hold_capture  = 1'b0;
    hold_drain    = 1'b0;
    hold_clear    = 1'b0;
    valid_f       = 1'b0;
    instr_f       = NOP_INSTR;
    pc_f          = fetch_pc_reg;
    imem_req_o    = 1'b0;
    imem_addr_o   = align_word(fetch_pc_reg);

    unique case (state_reg)
      BOOT: begin
        state_next = FETCH;
      end

      FETCH: begin
        // A redirect here retargets the request that is already on the bus.
        issue = 1'b1;
        if (pc_src_e) begin
          fetch_pc_next = redirect_pc;
          issue_addr    = redirect_pc;
        end
      end

      WAIT: begin
        if (pc_src_e) begin
          fetch_pc_next = redirect_pc;
          if (imem_rvalid_i) begin
            // The in-flight response is here now: drop it and refetch.
            discard_next = 1'b0;
            state_next   = FETCH;
          end else begin
            // Response still pending: drop it when it eventually shows up.
            discard_next = 1'b1;
          end
        end else if (imem_rvalid_i) begin
          if (discard_reg) begin
            discard_next = 1'b0;
            state_next   = FETCH;
          end else begin
            valid_f = 1'b1;
            instr_f = imem_rdata_i;
            if (stall_f) begin
              hold_capture = 1'b1;
              state_next   = HOLD;
            end else begin
              fetch_pc_next = pc_plus4;
              issue         = 1'b1;
              issue_addr    = pc_plus4;
            end
          end
        end
      end

      HOLD: begin
        if (pc_src_e) begin
          // Redirect beats stall: the parked instruction is squashed.
          fetch_pc_next = redirect_pc;
          hold_clear    = 1'b1;
          state_next    = FETCH;
        end else begin
          valid_f = hold_full;
          instr_f = hold_instr;
          pc_f    = hold_pc;
          if (!stall_f) begin
            hold_drain    = 1'b1;
            fetch_pc_next = pc_plus4;
            issue         = 1'b1;
            issue_addr    = pc_plus4;
          end
        end
      end

      default: begin
        state_next = BOOT;
      end
    endcase

    // Common request launch: a grant means the response is now outstanding.
    if (issue) begin
      if (fetch_block) begin
        state_next = FETCH;
      end else begin
        imem_req_o  = 1'b1;
        imem_addr_o = align_word(issue_addr);
        state_next  = imem_gnt_i ? WAIT : FETCH;
      end
    end
  end

  assign pc_next_f = pc_f + 32'd4;

  // Controller state, fetch PC and stale-response flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= BOOT;
      fetch_pc_reg <= RESET_PC;
      discard_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      discard_reg  <= discard_next;
    end
  end

endmodule
